ulaw_encode_writer: RTL
=======================

Name: ulaw_encode_writer

Overview:
- Streaming G.711 mu-law encoder and memory writer: the producer side of the 8-bit mu-law memory image that dnn_relu_ulaw reads through mem_addr/mem_data.
- Accepts signed 14-bit linear samples on a valid/ready stream and encodes each into an 8-bit mu-law code.
- Writes codes to consecutive addresses starting at ADDR_BASE, then raises done.
- Used to build activation/weight images in the format that the DNN's argmax compare expects.

Parameters:
ADDR_WIDTH, 16, memory address width
ADDR_BASE, 16'h0000, address of the first code written
COUNT, 400, samples per job (1..2^ADDR_WIDTH-ADDR_BASE)
LIN_WIDTH, 14, linear sample width; fixed at 14, other values unsupported

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
start  in  1  1-cycle pulse; begins a job from IDLE
reset  in  1  synchronous soft clear, active-high; returns to IDLE from any state
in_valid  in  1  sample valid
in_ready  out  1  encoder accepts sample this cycle
in_data  in  14  signed two's-complement linear sample
mem_addr  out  ADDR_WIDTH  write address
mem_data  out  8  mu-law code
mem_we  out  1  write strobe, one write per asserted cycle
busy  out  1  high in BUSY or FLUSH
done  out  1  high in DONE
count  out  ADDR_WIDTH  codes written in current job

Behaviour:
- Reset (rst=0 at posedge): state IDLE. in_ready=0, mem_we=0, mem_addr=ADDR_BASE, mem_data=8'hFF, busy=0, done=0, count=0, pipeline valids cleared.
- The soft reset input has the same effect as rst. It has priority over start and in_valid in the same cycle.
- FSM: IDLE -start-> BUSY; BUSY -COUNT-th sample accepted-> FLUSH; FLUSH -last write issued-> DONE; DONE -reset-> IDLE.
- start is ignored outside IDLE.
- in_ready = (state==BUSY), combinational from state. Accept = in_valid & in_ready.
- After the COUNT-th accept, in_ready drops on the next cycle, so exactly COUNT samples are accepted per job.
- Encoding (G.711, 14-bit):
  - s = in_data[13]; mag = s ? -in_data : in_data, computed in 15 bits so that -8192 gives 8192.
  - Clip mag to 8158, then b = mag + 33, a 13-bit value in 33..8191.
  - p = index of the MSB of b (5..12); chord = p-5; mant = b[p-1:p-4].
  - code = ~{s, chord[2:0], mant[3:0]}.
- Pipeline:
  - Stage 1 registers s and b on accept.
  - Stage 2 registers the code and drives the write.
  - mem_we rises 2 cycles after the accept edge. mem_data and mem_addr are valid while mem_we=1.
  - Fully pipelined: one sample per cycle sustained; bubbles on in_valid produce matching gaps in mem_we.
- Addressing:
  - The first write goes to ADDR_BASE; mem_addr increments by 1 after each write. count increments with each write.
  - Overflow past 2^ADDR_WIDTH-1 wraps to 0; not a legal configuration.
- FLUSH drains the 2 pipeline stages. The state enters DONE the cycle after the final mem_we.
- In DONE: done=1, count=COUNT, mem_we=0, mem_addr holds ADDR_BASE+COUNT.
- Mid-job rst or reset: the in-flight pipeline is discarded and no further mem_we is issued. Writes already made are not undone.
- The next job restarts at ADDR_BASE.

Test Plan:
- Sample code values, one per sample: 0->8'hFF, -1->8'h7E, 100->8'hDF, 8158->8'h80, 8191 (clip)->8'h80, -8192 (clip)->8'h00. Each code must land at sequential addresses.
- COUNT=400, in_valid held high: first mem_we exactly 2 cycles after the first accept. 400 contiguous write cycles, addresses ADDR_BASE..ADDR_BASE+399. done on the cycle after the last write; count=400.
- Random in_valid gaps: the write sequence equals the input order. Codes match a reference encoder. No duplicate or missing addresses.
- Extra samples after the COUNT-th: in_ready=0 and no further writes. start pulsed in BUSY/DONE has no effect.
- reset pulsed mid-job after 10 accepts: mem_we=0 from the next cycle; state IDLE; count=0. A following start rewrites from ADDR_BASE.
- rst low for 1 cycle during FLUSH: all outputs return to reset values and no pending write is emitted.
- Round-trip: encode 0..8191 with a bench decoder. Monotonic property: the DNN bench's cmp ordering over the codes matches the ordering of the linear inputs (ties allowed within the same code).

Source files
------------

// File: rtl/ulaw_encode_writer_if.sv
// Sample stream in, mu-law code writes out: the bus between a sample
// producer, the encoder and the memory image it fills.
interface ulaw_encode_writer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int LIN_WIDTH  = 14
);
  logic                  in_valid;
  logic                  in_ready;
  logic [LIN_WIDTH-1:0]  in_data;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_data;
  logic                  mem_we;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_addr, mem_data, mem_we
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_addr, mem_data, mem_we
  );
endinterface

// File: rtl/ulaw_encode_writer.sv
// Streaming G.711 mu-law encoder that writes COUNT codes to consecutive
// addresses from ADDR_BASE through a two-stage pipeline, then reports done.
module ulaw_encode_writer #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE  = '0,
  parameter int                    COUNT      = 400,
  parameter int                    LIN_WIDTH  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  reset,
  ulaw_encode_writer_if.slave   bus,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] count
);

  localparam int                   CNT_W    = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0]     LAST_ACC = CNT_W'(COUNT - 1);
  localparam logic [LIN_WIDTH:0]   MAG_MAX  = (LIN_WIDTH + 1)'(8158);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_FLUSH,
    ST_DONE
  } state_t;

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic [CNT_W-1:0]      r_acc_cnt;
  logic                  r_s1_valid;
  logic                  r_s1_s;
  logic [12:0]           r_s1_b;
  logic                  r_s2_valid;
  logic [7:0]            r_s2_code;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_count;

  logic                  w_clear;
  logic                  w_accept;
  logic                  w_sign;
  logic [LIN_WIDTH:0]    w_ext;
  logic [LIN_WIDTH:0]    w_mag;
  logic [12:0]           w_b;

  // Chord is the MSB position of the biased magnitude; mantissa is the next 4 bits.
  function automatic logic [7:0] f_encode(input logic s, input logic [12:0] b);
    logic [2:0] chord;
    logic [3:0] mant;
    chord = 3'd0;
    mant  = b[4:1];
    for (int p = 6; p <= 12; p++) begin
      if (b[p]) begin
        chord = 3'(p - 5);
        mant  = b[p-1 -: 4];
      end
    end
    return ~{s, chord, mant};
  endfunction

  assign w_clear      = !rst || reset;
  assign bus.in_ready = (r_state == ST_BUSY);
  assign w_accept     = bus.in_valid && bus.in_ready;

  always_comb begin
    // NOTE: every always_comb output is assigned on every path so no latch is inferred.
    w_sign = bus.in_data[LIN_WIDTH-1];
    w_ext  = {w_sign, bus.in_data};
    w_mag  = w_sign ? (~w_ext + 1'b1) : w_ext;
    if (w_mag > MAG_MAX) w_b = 13'd8191;
    else                 w_b = w_mag[12:0] + 13'd33;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_acc_cnt  <= '0;
      r_s1_valid <= 1'b0;
      r_s1_s     <= 1'b0;
      r_s1_b     <= '0;
      r_s2_valid <= 1'b0;
      r_s2_code  <= 8'hFF;
      r_addr     <= ADDR_BASE;
      r_count    <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_s <= w_sign;
        r_s1_b <= w_b;
      end

      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) r_s2_code <= f_encode(r_s1_s, r_s1_b);

      // Address and count advance once per issued write.
      if (r_s2_valid) begin
        r_addr  <= r_addr + 1'b1;
        r_count <= r_count + 1'b1;
      end

      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_BUSY;
            r_busy    <= 1'b1;
            r_acc_cnt <= '0;
            r_addr    <= ADDR_BASE;
            r_count   <= '0;
          end
        end
        ST_BUSY: begin
          if (w_accept) begin
            r_acc_cnt <= r_acc_cnt + 1'b1;
            if (r_acc_cnt == LAST_ACC) r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // Stage 1 empty means the final write is on the bus this cycle.
          if (!r_s1_valid) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_we   = r_s2_valid;
  assign bus.mem_data = r_s2_code;
  assign bus.mem_addr = r_addr;
  assign busy         = r_busy;
  assign done         = r_done;
  assign count        = r_count;

endmodule
